rv_ifetch_resp: RTL and testbench
=================================

RV_IFETCH_RESP -- requirements
Module: rv_ifetch_resp

Interface
REQ-001 Parameter DEPTH, default 2: maximum number of instructions in flight (outstanding plus buffered).
REQ-002 i_clk  in  1  clock; all state on rising edge.
REQ-003 i_reset_n  in  1  reset, synchronous, active-low.
REQ-004 i_pc  in  [31:2]  word address driven by the fetch PC generator.
REQ-005 i_pc_vld  in  1  i_pc is valid for issue.
REQ-006 o_pc_rdy  out  1  i_pc accepted this cycle; the PC generator advances.
REQ-007 i_flush  in  1  redirect (exec pc_sel); kill all buffered and in-flight fetches.
REQ-008 o_mem_req  out  1  instruction memory request.
REQ-009 o_mem_addr  out  [31:2]  request word address.
REQ-010 i_mem_gnt  in  1  memory accepted the request.
REQ-011 i_mem_rvalid  in  1  response valid; responses are in order, at least 1 cycle after grant.
REQ-012 i_mem_rdata  in  [31:0]  response instruction word.
REQ-013 o_instr_vld  out  1  instruction available to decode.
REQ-014 i_instr_rdy  in  1  decode consumes the instruction.
REQ-015 o_instr  out  [31:0]  head instruction; 32'h0000_0013 (NOP) when o_instr_vld=0.
REQ-016 o_instr_pc  out  [31:2]  address of the head instruction.

Function
REQ-017 The block SHALL track cnt_out (granted, not yet responded) and cnt_buf (buffer occupancy), each 0..DEPTH.
REQ-018 The block SHALL compute credit = (cnt_out + cnt_buf < DEPTH).
REQ-019 The block SHALL drive o_mem_req = i_pc_vld & credit & !i_flush combinationally, with o_mem_addr = i_pc.
REQ-020 The block SHALL drive o_pc_rdy = o_mem_req & i_mem_gnt; a grant SHALL push i_pc into an address FIFO of DEPTH entries and increment cnt_out.
REQ-021 On i_mem_rvalid with cnt_out>0, the block SHALL pop the address FIFO and decrement cnt_out; if discard_cnt=0, it SHALL write {address, rdata} into the instruction buffer.
REQ-022 Buffer output SHALL be registered: rvalid in cycle N yields o_instr_vld in cycle N+1 at the earliest.
REQ-023 Issue to response to decode SHALL preserve order; o_instr_vld=1 iff cnt_buf>0; a pop occurs on o_instr_vld & i_instr_rdy.
REQ-024 Simultaneous push and pop SHALL leave cnt_buf unchanged; credit SHALL make overflow impossible.
REQ-025 On i_flush, the block SHALL empty the buffer and set discard_cnt = cnt_out minus (1 if rvalid this cycle); later responses SHALL be dropped while discard_cnt>0, with discard_cnt decrementing per drop.
REQ-026 A response arriving in the flush cycle SHALL be dropped.
REQ-027 A decode pop in the flush cycle SHALL have no effect beyond the flush.
REQ-028 i_mem_rvalid with cnt_out=0 SHALL be ignored with no state change.
REQ-029 Stalled decode (i_instr_rdy=0) SHALL hold o_instr/o_instr_pc stable; issue SHALL stop when credit=0.

Reset
REQ-030 With i_reset_n=0 at a clock edge, the block SHALL clear cnt_out, cnt_buf, discard_cnt, and FIFO pointers.
REQ-031 During and after reset: o_mem_req=0 while in reset, o_instr_vld=0, o_instr=32'h0000_0013, o_instr_pc=0, o_pc_rdy=0.
REQ-032 Responses to requests in flight across reset SHALL be ignored per REQ-028.

Configuration
REQ-033 With RV_IFETCH_ERR_EN defined, the block SHALL add input i_mem_err (qualified by i_mem_rvalid) and output o_instr_err; the error bit SHALL be stored per buffer entry and presented with its instruction; discarded responses SHALL not raise it.
REQ-034 Without RV_IFETCH_ERR_EN, the block SHALL omit both ports and behave identically otherwise.

Verification
REQ-035 Back-to-back: i_pc 0x100,0x104 with gnt=1 and rvalid 1 cycle later (0xAAAA0001, 0xAAAA0002) -> decode receives them in order with o_instr_pc 0x100,0x104, first one 2 cycles after its grant.
REQ-036 Backpressure, DEPTH=2: i_instr_rdy=0 -> after 2 grants o_mem_req=0; one pop -> exactly one new request.
REQ-037 Flush with 2 outstanding, rdy=0 -> buffer empties; next 2 rvalids dropped; a new PC 0x200 issued after the flush is the first instruction delivered.
REQ-038 Flush coincident with rvalid and cnt_out=2 -> that response and the next are dropped, discard_cnt ends at 0.
REQ-039 Reset mid-stream with 1 outstanding, then a stray rvalid -> o_instr_vld stays 0.
REQ-040 With RV_IFETCH_ERR_EN: rvalid with i_mem_err=1 at 0x300 -> o_instr_err=1 only while 0x300 is at the head.

Source files
------------

// File: rtl/rv_ifetch_resp.sv
// Instruction-fetch response path: credit-limited issue, in-order response tracking, flush discard, registered decode buffer.
// Optional RV_IFETCH_ERR_EN adds i_mem_err / o_instr_err with a per-entry error bit.
module rv_ifetch_resp #(
  parameter int DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic [31:2] i_pc,
  input  logic        i_pc_vld,
  output logic        o_pc_rdy,
  input  logic        i_flush,
  output logic        o_mem_req,
  output logic [31:2] o_mem_addr,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
`ifdef RV_IFETCH_ERR_EN
  input  logic        i_mem_err,
  output logic        o_instr_err,
`endif
  output logic        o_instr_vld,
  input  logic        i_instr_rdy,
  output logic [31:0] o_instr,
  output logic [31:2] o_instr_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [CW-1:0] cnt_out_q, cnt_out_d;
  logic [CW-1:0] cnt_buf_q, cnt_buf_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] af_wr_q, af_wr_d;
  logic [PW-1:0] af_rd_q, af_rd_d;
  logic [PW-1:0] ib_wr_q, ib_wr_d;
  logic [PW-1:0] ib_rd_q, ib_rd_d;

  logic [31:2] af_mem_q  [DEPTH];
  logic [31:2] af_mem_d  [DEPTH];
  logic [31:2] ib_pc_q   [DEPTH];
  logic [31:2] ib_pc_d   [DEPTH];
  logic [31:0] ib_data_q [DEPTH];
  logic [31:0] ib_data_d [DEPTH];

  logic [CW:0] in_flight;
  logic        credit;
  logic        issue;
  logic        grant;
  logic        resp;
  logic        drop;
  logic        push;
  logic        pop;
  logic        instr_vld;

  // Outstanding requests still hold credit after a flush until their responses drain.
  always_comb begin
    in_flight = (CW + 1)'(cnt_out_q) + (CW + 1)'(cnt_buf_q);
    credit    = in_flight < (CW + 1)'(DEPTH);
    issue     = i_reset_n & i_pc_vld & credit & ~i_flush;
    grant     = issue & i_mem_gnt;
    resp      = i_mem_rvalid & (cnt_out_q != '0);
    drop      = resp & (i_flush | (discard_q != '0));
    push      = resp & ~drop;
    instr_vld = i_reset_n & (cnt_buf_q != '0);
    pop       = instr_vld & i_instr_rdy & ~i_flush;
  end

  always_comb begin
    cnt_out_d = cnt_out_q + CW'(grant) - CW'(resp);
    af_wr_d   = grant ? ptr_inc(af_wr_q) : af_wr_q;
    af_rd_d   = resp ? ptr_inc(af_rd_q) : af_rd_q;
    af_mem_d  = af_mem_q;
    if (grant) begin
      af_mem_d[af_wr_q] = i_pc;
    end

    discard_d = discard_q;
    if (i_flush) begin
      discard_d = cnt_out_q - CW'(resp);
    end else if (resp && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end
  end

  always_comb begin
    ib_pc_d   = ib_pc_q;
    ib_data_d = ib_data_q;
    if (push) begin
      ib_pc_d[ib_wr_q]   = af_mem_q[af_rd_q];
      ib_data_d[ib_wr_q] = i_mem_rdata;
    end

    if (i_flush) begin
      ib_wr_d   = '0;
      ib_rd_d   = '0;
      cnt_buf_d = '0;
    end else begin
      ib_wr_d   = push ? ptr_inc(ib_wr_q) : ib_wr_q;
      ib_rd_d   = pop ? ptr_inc(ib_rd_q) : ib_rd_q;
      cnt_buf_d = cnt_buf_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_out_q <= '0;
      cnt_buf_q <= '0;
      discard_q <= '0;
      af_wr_q   <= '0;
      af_rd_q   <= '0;
      ib_wr_q   <= '0;
      ib_rd_q   <= '0;
    end else begin
      cnt_out_q <= cnt_out_d;
      cnt_buf_q <= cnt_buf_d;
      discard_q <= discard_d;
      af_wr_q   <= af_wr_d;
      af_rd_q   <= af_rd_d;
      ib_wr_q   <= ib_wr_d;
      ib_rd_q   <= ib_rd_d;
    end
  end

  // Storage arrays carry no reset; counters and pointers alone define validity.
  always_ff @(posedge i_clk) begin
    af_mem_q  <= af_mem_d;
    ib_pc_q   <= ib_pc_d;
    ib_data_q <= ib_data_d;
  end

`ifdef RV_IFETCH_ERR_EN
  logic ib_err_q [DEPTH];
  logic ib_err_d [DEPTH];

  always_comb begin
    ib_err_d = ib_err_q;
    if (push) begin
      ib_err_d[ib_wr_q] = i_mem_err;
    end
  end

  always_ff @(posedge i_clk) begin
    ib_err_q <= ib_err_d;
  end

  assign o_instr_err = instr_vld & ib_err_q[ib_rd_q];
`endif

  assign o_mem_req   = issue;
  assign o_mem_addr  = i_pc;
  assign o_pc_rdy    = grant;
  assign o_instr_vld = instr_vld;
  assign o_instr     = instr_vld ? ib_data_q[ib_rd_q] : NOP;
  assign o_instr_pc  = instr_vld ? ib_pc_q[ib_rd_q] : '0;

endmodule

// File: tb/tb_rv_ifetch_resp.sv
// Directed scoreboard bench for rv_ifetch_resp: expected instructions are queued at response time
// and a negedge monitor checks every decode consumption against the queue.
module tb_rv_ifetch_resp;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        i_clk;
  logic        i_reset_n;
  logic [31:2] i_pc;
  logic        i_pc_vld;
  logic        o_pc_rdy;
  logic        i_flush;
  logic        o_mem_req;
  logic [31:2] o_mem_addr;
  logic        i_mem_gnt;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        i_mem_err;
  logic        o_instr_err;
  logic        o_instr_vld;
  logic        i_instr_rdy;
  logic [31:0] o_instr;
  logic [31:2] o_instr_pc;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  rv_ifetch_resp #(.DEPTH(2)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_pc         (i_pc),
    .i_pc_vld     (i_pc_vld),
    .o_pc_rdy     (o_pc_rdy),
    .i_flush      (i_flush),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .i_mem_gnt    (i_mem_gnt),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
`ifdef RV_IFETCH_ERR_EN
    .i_mem_err    (i_mem_err),
    .o_instr_err  (o_instr_err),
`endif
    .o_instr_vld  (o_instr_vld),
    .i_instr_rdy  (i_instr_rdy),
    .o_instr      (o_instr),
    .o_instr_pc   (o_instr_pc)
  );

`ifndef RV_IFETCH_ERR_EN
  assign o_instr_err = 1'b0;
`endif

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: inputs change just after the rising edge, outputs are sampled at the falling edge.
  task automatic applyStimulus(input logic rst_n, input logic pc_vld, input logic [31:0] pc,
                               input logic gnt, input logic rvalid, input logic [31:0] rdata,
                               input logic err, input logic flush, input logic rdy);
    @(posedge i_clk);
    #1;
    i_reset_n    = rst_n;
    i_pc_vld     = pc_vld;
    i_pc         = pc[31:2];
    i_mem_gnt    = gnt;
    i_mem_rvalid = rvalid;
    i_mem_rdata  = rdata;
    i_mem_err    = err;
    i_flush      = flush;
    i_instr_rdy  = rdy;
    @(negedge i_clk);
  endtask

  task automatic expectInstr(input logic [31:0] pc, input logic [31:0] instr, input logic err);
    exp_t e;
    e.pc    = pc;
    e.instr = instr;
    e.err   = err;
    sb.push_back(e);
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, rdy);
  endtask

  always @(negedge i_clk) begin : monitor
    exp_t e;
    if (i_reset_n === 1'b1 && o_instr_vld === 1'b1 && i_instr_rdy === 1'b1 && i_flush === 1'b0) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected_instr: got %h at pc %h, expected nothing", o_instr, {o_instr_pc, 2'b00});
      end else begin
        e = sb.pop_front();
        checkOutput("instr", o_instr, e.instr);
        checkOutput("instr_pc", {o_instr_pc, 2'b00}, e.pc);
        checkOutput("instr_err", 32'(o_instr_err), 32'(e.err));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_reset_n = 1'b0; i_pc_vld = 1'b0; i_pc = '0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
    i_mem_rdata = '0; i_mem_err = 1'b0; i_flush = 1'b0; i_instr_rdy = 1'b0;

    $display("[TB] reset");
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("rst_mem_req", 32'(o_mem_req), 32'd0);
    checkOutput("rst_pc_rdy", 32'(o_pc_rdy), 32'd0);
    checkOutput("rst_instr_vld", 32'(o_instr_vld), 32'd0);
    checkOutput("rst_instr", o_instr, 32'h0000_0013);
    checkOutput("rst_instr_pc", {o_instr_pc, 2'b00}, 32'h0);

    $display("[TB] back-to-back");
    applyStimulus(1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("b2b_req0", 32'(o_mem_req), 32'd1);
    checkOutput("b2b_addr0", {o_mem_addr, 2'b00}, 32'h100);
    checkOutput("b2b_pc_rdy0", 32'(o_pc_rdy), 32'd1);
    expectInstr(32'h100, 32'hAAAA_0001, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h104, 1'b1, 1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b1);
    checkOutput("b2b_vld_c1", 32'(o_instr_vld), 32'd0);
    checkOutput("b2b_req1", 32'(o_mem_req), 32'd1);
    expectInstr(32'h104, 32'hAAAA_0002, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hAAAA_0002, 1'b0, 1'b0, 1'b1);
    checkOutput("b2b_vld_c2", 32'(o_instr_vld), 32'd1);
    idle(1'b1);
    idle(1'b1);
    checkOutput("b2b_drained_vld", 32'(o_instr_vld), 32'd0);
    checkOutput("b2b_drained_nop", o_instr, 32'h0000_0013);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 1'b1, 32'h110, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h114, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    expectInstr(32'h110, 32'hBBBB_0001, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h118, 1'b1, 1'b1, 32'hBBBB_0001, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_req_nocredit", 32'(o_mem_req), 32'd0);
    checkOutput("bp_pc_rdy_nocredit", 32'(o_pc_rdy), 32'd0);
    expectInstr(32'h114, 32'hBBBB_0002, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h118, 1'b1, 1'b1, 32'hBBBB_0002, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_req_c3", 32'(o_mem_req), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h118, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_req_full", 32'(o_mem_req), 32'd0);
    checkOutput("bp_stall_pc", {o_instr_pc, 2'b00}, 32'h110);
    checkOutput("bp_stall_instr", o_instr, 32'hBBBB_0001);
    applyStimulus(1'b1, 1'b1, 32'h118, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("bp_req_popcycle", 32'(o_mem_req), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h118, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_req_after_pop", 32'(o_mem_req), 32'd1);
    expectInstr(32'h118, 32'hBBBB_0003, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h11C, 1'b1, 1'b1, 32'hBBBB_0003, 1'b0, 1'b0, 1'b0);
    checkOutput("bp_req_one_only", 32'(o_mem_req), 32'd0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);
    checkOutput("bp_drained_vld", 32'(o_instr_vld), 32'd0);

    $display("[TB] flush with two outstanding");
    applyStimulus(1'b1, 1'b1, 32'h120, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h124, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    checkOutput("fl_req_in_flush", 32'(o_mem_req), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hCCCC_0001, 1'b0, 1'b0, 1'b1);
    checkOutput("fl_buf_empty", 32'(o_instr_vld), 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h200, 1'b1, 1'b1, 32'hCCCC_0002, 1'b0, 1'b0, 1'b1);
    checkOutput("fl_new_req", 32'(o_mem_req), 32'd1);
    expectInstr(32'h200, 32'hDDDD_0000, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDDDD_0000, 1'b0, 1'b0, 1'b1);
    checkOutput("fl_dropped_vld", 32'(o_instr_vld), 32'd0);
    idle(1'b1);
    idle(1'b1);
    checkOutput("fl_drained_vld", 32'(o_instr_vld), 32'd0);

    $display("[TB] flush with buffered entry and pop in flush cycle");
    applyStimulus(1'b1, 1'b1, 32'h130, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h134, 1'b1, 1'b1, 32'hEEEE_0001, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    checkOutput("flb_vld_before", 32'(o_instr_vld), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hEEEE_0002, 1'b0, 1'b0, 1'b1);
    checkOutput("flb_buf_empty", 32'(o_instr_vld), 32'd0);
    idle(1'b1);
    checkOutput("flb_still_empty", 32'(o_instr_vld), 32'd0);

    $display("[TB] flush coincident with response");
    applyStimulus(1'b1, 1'b1, 32'h140, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h144, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_0001, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_0002, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h150, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("flc_req", 32'(o_mem_req), 32'd1);
    expectInstr(32'h150, 32'hFFFF_0003, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_0003, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 1'b1, 32'h160, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, 32'h164, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    checkOutput("mrst_req", 32'(o_mem_req), 32'd0);
    checkOutput("mrst_pc_rdy", 32'(o_pc_rdy), 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h9999_0001, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    checkOutput("mrst_stray_vld", 32'(o_instr_vld), 32'd0);
    idle(1'b1);
    checkOutput("mrst_stray_vld2", 32'(o_instr_vld), 32'd0);
    checkOutput("mrst_nop", o_instr, 32'h0000_0013);

`ifdef RV_IFETCH_ERR_EN
    $display("[TB] error flag");
    applyStimulus(1'b1, 1'b1, 32'h300, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    expectInstr(32'h300, 32'h1111_0001, 1'b1);
    applyStimulus(1'b1, 1'b1, 32'h304, 1'b1, 1'b1, 32'h1111_0001, 1'b1, 1'b0, 1'b0);
    expectInstr(32'h304, 32'h1111_0002, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1111_0002, 1'b0, 1'b0, 1'b0);
    checkOutput("err_head", 32'(o_instr_err), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    checkOutput("err_second", 32'(o_instr_err), 32'd0);
    idle(1'b1);
    idle(1'b1);
    checkOutput("err_idle", 32'(o_instr_err), 32'd0);
`endif

    idle(1'b1);
    idle(1'b1);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
